// File: rtl/fifo_read_controller.sv
// Read-domain side of the async FIFO: read pointer, empty/fill from the synced write pointer,
// registered-RAM sequencing and a first-word-fall-through output. Optional: FIFO_READ_ALMOST_EMPTY_EN.
module fifo_read_controller #(
  parameter int DEPTH              = 16,
  parameter int DATA_WIDTH         = 8,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  localparam int AW                = $clog2(DEPTH)
) (
  input  logic                  read_clock,
  input  logic                  read_reset_n,
  input  logic [AW:0]           synced_write_pointer,
  output logic [AW:0]           read_pointer,
  output logic                  mem_read_en,
  output logic [AW-1:0]         mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  empty,
  output logic [AW:0]           fill_level
`ifdef FIFO_READ_ALMOST_EMPTY_EN
  ,
  output logic                  almost_empty
`endif
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, MEM, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [AW:0]             read_bin, read_bin_nxt, write_bin;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    fetch, hold_load;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign write_bin     = gray2bin(synced_write_pointer);
  assign fill_level    = write_bin - read_bin;
  assign empty         = (read_bin == write_bin);
  assign read_bin_nxt  = read_bin + 1'b1;
  assign mem_read_addr = read_bin[AW-1:0];
  assign mem_read_en   = fetch;

`ifdef FIFO_READ_ALMOST_EMPTY_EN
  localparam logic [AW:0] AE_LVL = (AW+1)'(ALMOST_EMPTY_LEVEL);
  assign almost_empty = !read_reset_n || (fill_level <= AE_LVL);
`endif

  always_ff @(posedge read_clock) begin
    if (!read_reset_n) begin
      state        <= IDLE;
      read_bin     <= '0;
      read_pointer <= '0;
      hold_data    <= '0;
    end else begin
      state <= state_nxt;
      if (fetch) begin
        read_bin     <= read_bin_nxt;
        read_pointer <= read_bin_nxt ^ (read_bin_nxt >> 1);
      end
      if (hold_load) hold_data <= mem_read_data;
    end
  end

  // MEM presents the RAM output directly; HOLD parks it when the consumer stalls
  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    hold_load = 1'b0;
    out_valid = 1'b0;
    out_data  = hold_data;
    case (state)
      IDLE: begin
        if (!empty) begin
          fetch     = 1'b1;
          state_nxt = MEM;
        end
      end
      MEM: begin
        out_valid = 1'b1;
        out_data  = mem_read_data;
        if (out_ready) begin
          if (!empty) fetch = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          hold_load = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!empty) begin
            fetch     = 1'b1;
            state_nxt = MEM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // reset masks the stream immediately, not just from the next edge
    if (!read_reset_n) begin
      fetch     = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
    end
  end

  a_fill_legal: assert property (@(posedge read_clock) disable iff (!read_reset_n)
    (fill_level <= DEPTH_W) && (ALMOST_EMPTY_LEVEL <= DEPTH));

endmodule
